// File: rtl/multicycle_control_fsm_pkg.sv
// Shared encodings for the multi-cycle RV32I control path: opcodes, FSM states,
// datapath select codes and the opcode class record.
package multicycle_control_fsm_pkg;

    localparam logic [4:0] OPCODE_LOAD   = 5'b00000;
    localparam logic [4:0] OPCODE_STORE  = 5'b01000;
    localparam logic [4:0] OPCODE_OPIMM  = 5'b00100;
    localparam logic [4:0] OPCODE_OP     = 5'b01100;
    localparam logic [4:0] OPCODE_AUIPC  = 5'b00101;
    localparam logic [4:0] OPCODE_LUI    = 5'b01101;
    localparam logic [4:0] OPCODE_BRANCH = 5'b11000;
    localparam logic [4:0] OPCODE_JALR   = 5'b11001;
    localparam logic [4:0] OPCODE_JAL    = 5'b11011;
    localparam logic [4:0] OPCODE_SYSTEM = 5'b11100;

    typedef enum logic [2:0] {
        S_FETCH     = 3'd0,
        S_DECODE    = 3'd1,
        S_EXECUTE   = 3'd2,
        S_MEM       = 3'd3,
        S_WRITEBACK = 3'd4,
        S_HALT      = 3'd5
    } state_t;

    localparam logic [1:0] PC_SRC_PC4    = 2'd0;
    localparam logic [1:0] PC_SRC_TARGET = 2'd1;
    localparam logic [1:0] PC_SRC_JALR   = 2'd2;

    localparam logic [1:0] WB_SEL_ALU = 2'd0;
    localparam logic [1:0] WB_SEL_MEM = 2'd1;
    localparam logic [1:0] WB_SEL_PC4 = 2'd2;

    localparam logic [1:0] ALU_A_RS1  = 2'd0;
    localparam logic [1:0] ALU_A_PC   = 2'd1;
    localparam logic [1:0] ALU_A_ZERO = 2'd2;

    localparam logic ALU_B_RS2 = 1'b0;
    localparam logic ALU_B_IMM = 1'b1;

    typedef struct packed {
        logic alu;
        logic load;
        logic store;
        logic branch;
        logic jal;
        logic jalr;
        logic lui;
        logic auipc;
        logic system;
        logic illegal;
    } opcode_class_t;

endpackage

// File: rtl/multicycle_control_fsm_opcode_class_decode.sv
// Combinational opcode (inst[6:2]) to one-hot instruction class; exactly one
// field is set for any input, unknown opcodes land in the illegal class.
module opcode_class_decode
    import multicycle_control_fsm_pkg::*;
(
    input  logic [4:0]    opcode,
    output opcode_class_t cls
);

    always_comb begin
        cls = '0;
        case (opcode)
            OPCODE_OP,
            OPCODE_OPIMM:  cls.alu     = 1'b1;
            OPCODE_LOAD:   cls.load    = 1'b1;
            OPCODE_STORE:  cls.store   = 1'b1;
            OPCODE_BRANCH: cls.branch  = 1'b1;
            OPCODE_JAL:    cls.jal     = 1'b1;
            OPCODE_JALR:   cls.jalr    = 1'b1;
            OPCODE_LUI:    cls.lui     = 1'b1;
            OPCODE_AUIPC:  cls.auipc   = 1'b1;
            OPCODE_SYSTEM: cls.system  = 1'b1;
            default:       cls.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle RV32I control FSM over one shared variable-latency memory port.
// Optional PERF_CNT_EN adds cycle_cnt / instret_cnt outputs.
module multicycle_control_fsm
    import multicycle_control_fsm_pkg::*;
#(
    parameter logic [2:0] RESET_STATE     = 3'd0,
    parameter bit         HALT_ON_ILLEGAL = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] opcode,
    input  logic       branch_taken,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       mem_addr_sel,
    output logic       ir_we,
    output logic       pc_we,
    output logic [1:0] pc_src,
    output logic [1:0] alu_a_sel,
    output logic       alu_b_sel,
    output logic       rf_we,
    output logic [1:0] wb_sel,
    output logic       halted,
    output logic       illegal,
    output logic [2:0] state_dbg
`ifdef PERF_CNT_EN
    ,
    output logic [31:0] cycle_cnt,
    output logic [31:0] instret_cnt
`endif
);

    state_t        state;
    logic          illegal_q;
    opcode_class_t cls;

    opcode_class_decode u_decode (
        .opcode (opcode),
        .cls    (cls)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= state_t'(RESET_STATE);
            illegal_q <= 1'b0;
        end else begin
            case (state)
                S_FETCH:     if (mem_ready) state <= S_DECODE;
                S_DECODE:    state <= S_EXECUTE;
                S_EXECUTE: begin
                    if (cls.branch)
                        state <= S_FETCH;
                    else if (cls.load || cls.store)
                        state <= S_MEM;
                    else if (cls.system)
                        state <= S_HALT;
                    else if (cls.illegal) begin
                        if (HALT_ON_ILLEGAL) begin
                            state     <= S_HALT;
                            illegal_q <= 1'b1;
                        end else begin
                            state <= S_FETCH;
                        end
                    end else
                        state <= S_WRITEBACK;
                end
                S_MEM:       if (mem_ready) state <= cls.store ? S_FETCH : S_WRITEBACK;
                S_WRITEBACK: state <= S_FETCH;
                S_HALT:      state <= S_HALT;
                default:     state <= S_FETCH;
            endcase
        end
    end

    // Outputs follow state plus same-cycle inputs; rst masks them so an
    // in-flight memory request drops without waiting for a clock edge.
    always_comb begin
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr_sel = 1'b0;
        ir_we        = 1'b0;
        pc_we        = 1'b0;
        pc_src       = PC_SRC_PC4;
        alu_a_sel    = ALU_A_RS1;
        alu_b_sel    = ALU_B_RS2;
        rf_we        = 1'b0;
        wb_sel       = WB_SEL_ALU;
        halted       = 1'b0;
        illegal      = 1'b0;
        if (!rst) begin
            case (state)
                S_FETCH: begin
                    mem_req = 1'b1;
                    ir_we   = mem_ready;
                end
                S_EXECUTE: begin
                    if (cls.alu) begin
                        alu_a_sel = ALU_A_RS1;
                        alu_b_sel = (opcode == OPCODE_OP) ? ALU_B_RS2 : ALU_B_IMM;
                    end else if (cls.load || cls.store || cls.jalr) begin
                        alu_a_sel = ALU_A_RS1;
                        alu_b_sel = ALU_B_IMM;
                    end else if (cls.auipc) begin
                        alu_a_sel = ALU_A_PC;
                        alu_b_sel = ALU_B_IMM;
                    end else if (cls.lui) begin
                        alu_a_sel = ALU_A_ZERO;
                        alu_b_sel = ALU_B_IMM;
                    end
                    if (cls.branch) begin
                        pc_we  = 1'b1;
                        pc_src = branch_taken ? PC_SRC_TARGET : PC_SRC_PC4;
                    end else if (cls.illegal && !HALT_ON_ILLEGAL) begin
                        pc_we  = 1'b1;
                        pc_src = PC_SRC_PC4;
                    end
                end
                S_MEM: begin
                    mem_req      = 1'b1;
                    mem_addr_sel = 1'b1;
                    mem_we       = cls.store;
                    if (mem_ready && cls.store) begin
                        pc_we  = 1'b1;
                        pc_src = PC_SRC_PC4;
                    end
                end
                S_WRITEBACK: begin
                    rf_we = 1'b1;
                    pc_we = 1'b1;
                    if (cls.load)
                        wb_sel = WB_SEL_MEM;
                    else if (cls.jal || cls.jalr)
                        wb_sel = WB_SEL_PC4;
                    if (cls.jal)
                        pc_src = PC_SRC_TARGET;
                    else if (cls.jalr)
                        pc_src = PC_SRC_JALR;
                end
                S_HALT: begin
                    halted  = 1'b1;
                    illegal = illegal_q;
                end
                default: ;
            endcase
        end
    end

    assign state_dbg = state;

`ifdef PERF_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycle_cnt   <= 32'd0;
            instret_cnt <= 32'd0;
        end else begin
            if (state != S_HALT)
                cycle_cnt <= cycle_cnt + 32'd1;
            if (pc_we)
                instret_cnt <= instret_cnt + 32'd1;
        end
    end
`endif

endmodule
